// File: rtl/dual_issue_scheduler.sv
// Dual-slot issue controller: pops 0, 1 or 2 head instructions per cycle in order,
// gated by a register scoreboard, intra-pair hazards, shared-unit conflicts and serialization.
module dual_issue_scheduler #(
  parameter  int NUM_REGS = 32,
  parameter  int CNT_W    = 32,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [1:0]             iq_valid_i,
  input  logic [1:0][RW-1:0]     rs1_i,
  input  logic [1:0][RW-1:0]     rs2_i,
  input  logic [1:0]             use_rs1_i,
  input  logic [1:0]             use_rs2_i,
  input  logic [1:0][RW-1:0]     rd_i,
  input  logic [1:0]             we_i,
  input  logic [1:0]             mem_i,
  input  logic [1:0]             serial_i,
  input  logic                   exe_ready_i,
  input  logic [1:0]             wb_valid_i,
  input  logic [1:0][RW-1:0]     wb_rd_i,
  output logic [1:0]             read_head_o,
  output logic [NUM_REGS-1:0]    busy_o,
  output logic                   drain_o,
  output logic [CNT_W-1:0]       stall_cnt_o
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    stall_cnt_q;
  logic [1:0]          reg_haz;
  logic                any_busy;
  logic                intra_haz;
  logic                issue0, issue1;

  // Decision stage: combinational from queue head and registered scoreboard
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      reg_haz[k] = (use_rs1_i[k] & busy_q[rs1_i[k]]) |
                   (use_rs2_i[k] & busy_q[rs2_i[k]]) |
                   (we_i[k] & busy_q[rd_i[k]]);
    end
  end

  assign any_busy  = |busy_q;
  assign intra_haz = we_i[0] && (rd_i[0] != '0) &&
                     ((use_rs1_i[1] && (rs1_i[1] == rd_i[0])) ||
                      (use_rs2_i[1] && (rs2_i[1] == rd_i[0])) ||
                      (we_i[1] && (rd_i[1] == rd_i[0])));

  // DRAIN holds the serializing head until the scoreboard empties
  assign issue0 = !rst_i && iq_valid_i[0] && exe_ready_i && !flush_i && !reg_haz[0] &&
                  !(serial_i[0] && any_busy) && !((state_q == DRAIN) && any_busy);

  assign issue1 = issue0 && iq_valid_i[1] && !reg_haz[1] && !serial_i[1] && !serial_i[0] &&
                  !(mem_i[0] && mem_i[1]) && !intra_haz;

  assign read_head_o = {issue1, issue0};

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < 2; k++) begin
      if (wb_valid_i[k]) busy_d[wb_rd_i[k]] = 1'b0;
    end
    // sets applied after clears so an issuing writer keeps its bit
    for (int k = 0; k < 2; k++) begin
      if (read_head_o[k] && we_i[k] && (rd_i[k] != '0)) busy_d[rd_i[k]] = 1'b1;
    end
    busy_d[0] = 1'b0;
    if (flush_i) busy_d = '0;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (iq_valid_i[0] && serial_i[0] && any_busy && exe_ready_i) state_d = DRAIN;
        DRAIN:   if (issue0) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Registered state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (iq_valid_i[0] && !read_head_o[0] && !flush_i && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign busy_o      = busy_q;
  assign drain_o     = (state_q == DRAIN);
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed bench for dual_issue_scheduler; counter narrowed to 4 bits so saturation is reachable.
module tb_dual_issue_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [1:0]      iq_valid;
  logic [1:0][4:0] rs1, rs2, rd, wb_rd;
  logic [1:0]      use_rs1, use_rs2, we, mem, serial, wb_valid;
  logic            exe_ready;
  logic [1:0]      read_head;
  logic [31:0]     busy;
  logic            drain;
  logic [3:0]      stall_cnt;

  int total = 0;
  int bad   = 0;

  dual_issue_scheduler #(.NUM_REGS(32), .CNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .iq_valid_i(iq_valid),
    .rs1_i(rs1), .rs2_i(rs2), .use_rs1_i(use_rs1), .use_rs2_i(use_rs2),
    .rd_i(rd), .we_i(we), .mem_i(mem), .serial_i(serial), .exe_ready_i(exe_ready),
    .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .read_head_o(read_head),
    .busy_o(busy), .drain_o(drain), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; iq_valid = '0; rs1 = '0; rs2 = '0; rd = '0; wb_rd = '0;
    use_rs1 = '0; use_rs2 = '0; we = '0; mem = '0; serial = '0; wb_valid = '0;
    exe_ready = 1;
  endtask

  task automatic set_slot(input int k, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic w, input logic m, input logic s);
    iq_valid[k] = 1; rs1[k] = a; rs2[k] = b; use_rs1[k] = 1; use_rs2[k] = 1;
    rd[k] = d; we[k] = w; mem[k] = m; serial[k] = s;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1;
    set_slot(0, 5'd2, 5'd3, 5'd1, 1, 0, 0);
    #1;
    total++; if (read_head !== 2'b00) begin bad++; $display("FAIL reset_rh: got %b want 00", read_head); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL reset_busy: got %h want 0", busy); end
    total++; if (drain !== 1'b0) begin bad++; $display("FAIL reset_drain: got %b want 0", drain); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    tick();
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_independent();
    do_reset();
    set_slot(0, 5'd2, 5'd3, 5'd1, 1, 0, 0);
    set_slot(1, 5'd5, 5'd6, 5'd4, 1, 0, 0);
    #1;
    total++; if (read_head !== 2'b11) begin bad++; $display("FAIL indep_rh: got %b want 11", read_head); end
    tick();
    clear_inputs();
    #1;
    total++; if (busy !== 32'h0000_0012) begin bad++; $display("FAIL indep_busy: got %h want 00000012", busy); end
  endtask

  task automatic test_intra_raw();
    do_reset();
    set_slot(0, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    set_slot(1, 5'd5, 5'd3, 5'd6, 1, 0, 0);
    #1;
    total++; if (read_head !== 2'b01) begin bad++; $display("FAIL raw_pair_rh: got %b want 01", read_head); end
    tick();
    clear_inputs();
    set_slot(0, 5'd5, 5'd3, 5'd6, 1, 0, 0);
    #1;
    total++; if (read_head !== 2'b00) begin bad++; $display("FAIL raw_stall_rh: got %b want 00", read_head); end
    total++; if (busy !== 32'h0000_0020) begin bad++; $display("FAIL raw_busy5: got %h want 00000020", busy); end
    tick();
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL raw_cnt1: got %0d want 1", stall_cnt); end
    wb_valid[0] = 1; wb_rd[0] = 5'd5;
    #1;
    total++; if (read_head !== 2'b00) begin bad++; $display("FAIL raw_no_bypass: got %b want 00", read_head); end
    tick();
    wb_valid = '0;
    #1;
    total++; if (read_head !== 2'b01) begin bad++; $display("FAIL raw_after_wb: got %b want 01", read_head); end
    total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL raw_cnt2: got %0d want 2", stall_cnt); end
    tick();
    clear_inputs();
  endtask

  task automatic test_dual_mem();
    do_reset();
    set_slot(0, 5'd1, 5'd2, 5'd0, 1, 1, 0);
    set_slot(1, 5'd3, 5'd4, 5'd0, 1, 1, 0);
    #1;
    total++; if (read_head !== 2'b01) begin bad++; $display("FAIL mem_rh: got %b want 01", read_head); end
    tick();
    mem[0] = 0;
    #1;
    total++; if (read_head !== 2'b11) begin bad++; $display("FAIL mem_x0_rh: got %b want 11", read_head); end
    tick();
    clear_inputs();
    #1;
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL mem_x0_busy: got %h want 0", busy); end
  endtask

  task automatic test_exe_ready();
    do_reset();
    set_slot(0, 5'd2, 5'd3, 5'd1, 1, 0, 0);
    set_slot(1, 5'd5, 5'd6, 5'd4, 1, 0, 0);
    exe_ready = 0;
    #1;
    total++; if (read_head !== 2'b00) begin bad++; $display("FAIL exe_rh: got %b want 00", read_head); end
    tick();
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL exe_busy: got %h want 0", busy); end
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL exe_cnt: got %0d want 1", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_serial();
    do_reset();
    set_slot(0, 5'd1, 5'd2, 5'd7, 1, 0, 0);
    tick();
    clear_inputs();
    set_slot(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    set_slot(1, 5'd10, 5'd11, 5'd12, 1, 0, 0);
    #1;
    total++; if (read_head !== 2'b00) begin bad++; $display("FAIL ser_rh0: got %b want 00", read_head); end
    tick();
    total++; if (drain !== 1'b1) begin bad++; $display("FAIL ser_drain: got %b want 1", drain); end
    total++; if (read_head !== 2'b00) begin bad++; $display("FAIL ser_rh1: got %b want 00", read_head); end
    wb_valid[1] = 1; wb_rd[1] = 5'd7;
    tick();
    wb_valid = '0;
    #1;
    total++; if (read_head !== 2'b01) begin bad++; $display("FAIL ser_alone: got %b want 01", read_head); end
    tick();
    clear_inputs();
    #1;
    total++; if (drain !== 1'b0) begin bad++; $display("FAIL ser_back_run: got %b want 0", drain); end
    total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL ser_cnt: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_set_clear_flush();
    do_reset();
    set_slot(0, 5'd1, 5'd2, 5'd9, 1, 0, 0);
    wb_valid[0] = 1; wb_rd[0] = 5'd9;
    #1;
    total++; if (read_head !== 2'b01) begin bad++; $display("FAIL scf_rh: got %b want 01", read_head); end
    tick();
    clear_inputs();
    #1;
    total++; if (busy !== 32'h0000_0200) begin bad++; $display("FAIL scf_set_wins: got %h want 00000200", busy); end
    set_slot(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    tick();
    total++; if (drain !== 1'b1) begin bad++; $display("FAIL scf_drain: got %b want 1", drain); end
    set_slot(0, 5'd1, 5'd2, 5'd3, 1, 0, 0);
    serial = '0;
    flush = 1;
    #1;
    total++; if (read_head !== 2'b00) begin bad++; $display("FAIL scf_flush_rh: got %b want 00", read_head); end
    tick();
    clear_inputs();
    #1;
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL scf_flush_busy: got %h want 0", busy); end
    total++; if (drain !== 1'b0) begin bad++; $display("FAIL scf_flush_run: got %b want 0", drain); end
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL scf_flush_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_slot(0, 5'd1, 5'd2, 5'd3, 1, 0, 0);
    tick();
    clear_inputs();
    set_slot(0, 5'd3, 5'd4, 5'd8, 1, 0, 0);
    for (int i = 0; i < 14; i++) tick();
    total++; if (stall_cnt !== 4'd14) begin bad++; $display("FAIL sat_14: got %0d want 14", stall_cnt); end
    for (int i = 0; i < 3; i++) tick();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
    clear_inputs();
    set_slot(0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    tick();
    total++; if (drain !== 1'b1) begin bad++; $display("FAIL sat_drain: got %b want 1", drain); end
    #2;
    rst = 1;
    #1;
    total++; if (drain !== 1'b0) begin bad++; $display("FAIL async_drain: got %b want 0", drain); end
    total++; if (busy !== 32'h0) begin bad++; $display("FAIL async_busy: got %h want 0", busy); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL async_cnt: got %0d want 0", stall_cnt); end
    total++; if (read_head !== 2'b00) begin bad++; $display("FAIL async_rh: got %b want 00", read_head); end
    tick();
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_independent();
    test_intra_raw();
    test_dual_mem();
    test_exe_ready();
    test_serial();
    test_set_clear_flush();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_issue_scheduler.md
# dual_issue_scheduler

Issue-side controller for the dual-slot instruction queue in the IR stage. Each cycle it inspects the two instructions at the head of the queue and decides how many to pop, 0, 1 or 2, in program order. The decision uses a register scoreboard, intra-pair hazards, single-instance unit conflicts, serializing instructions and downstream backpressure. Its per-slot read-head outputs drive the queue's read inputs directly, and the scoreboard is cleared by the writeback stage.

## Interface
Parameters:
- NUM_REGS, default 32: architectural registers tracked; register index width RW = $clog2(NUM_REGS).
- CNT_W, default 32: width of the stall counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  pipeline flush; synchronous.
- iq_valid_i  in  2  bit k set: queue output slot k holds a valid instruction (slot 0 is oldest).
- rs1_i, rs2_i  in  2×RW  source registers per slot.
- use_rs1_i, use_rs2_i  in  2  source is actually read.
- rd_i  in  2×RW  destination register per slot.
- we_i  in  2  slot writes rd.
- mem_i  in  2  slot needs the single load/store unit.
- serial_i  in  2  slot is serializing (CSR, fence).
- exe_ready_i  in  1  execute stage accepts instructions this cycle.
- wb_valid_i  in  2  writeback port k retires a register write.
- wb_rd_i  in  2×RW  register retired on port k.
- read_head_o  out  2  pop slot k this cycle; combinational; read_head_o[1] implies read_head_o[0].
- busy_o  out  NUM_REGS  registered scoreboard.
- drain_o  out  1  FSM is in DRAIN.
- stall_cnt_o  out  CNT_W  saturating count of stalled cycles.

## Operation
- Scoreboard: one busy bit per register. Bit 0 (x0) is never set.
- Source hazard: a slot has one if it reads a used rs whose busy bit is set. Its WAW hazard: we and rd busy.
- Slot 0 issues when all of the following hold:
  - iq_valid_i[0], exe_ready_i and !flush_i;
  - no source or WAW hazard;
  - if serial_i[0], all busy bits are 0.
- Slot 1 issues when all of the following hold:
  - slot 0 issues and iq_valid_i[1];
  - no source or WAW hazard against the scoreboard;
  - serial_i[1]=0 and serial_i[0]=0;
  - not (mem_i[0] & mem_i[1]);
  - no intra-pair hazard. This is defined as: we_i[0] and rd_i[0]≠0, and rd_i[0] equals a used source of slot 1, or (we_i[1] and rd_i[1]=rd_i[0]).
- Each issued slot with we and rd≠0 sets busy[rd] at the next edge.
- A valid wb_valid_i[k] clears busy[wb_rd_i[k]] at the next edge.
- If a set and a clear hit the same register in the same cycle, the set wins.
- Hazard checks use only the registered busy bits. There is no same-cycle writeback bypass.
- FSM states:
  - RUN to DRAIN: iq_valid_i[0] & serial_i[0] & busy≠0 & !flush_i.
  - DRAIN: no issue until busy=0. It returns to RUN on the cycle the serializing instruction issues, which is always alone.
  - Any state to RUN on flush_i.
- flush_i: read_head_o=0 that cycle; all busy bits cleared and state set to RUN at the next edge. Flush overrides same-cycle writeback and issue.
- Stall counter: increments when iq_valid_i[0] & !read_head_o[0] & !flush_i. It saturates at all-ones and is not cleared by flush.

## Timing
- Reset (rst_i=1, asynchronous): busy_o=0, FSM in RUN, drain_o=0, stall_cnt_o=0. read_head_o is forced to 0 while rst_i is high.
- Issue decision latency: 0 cycles. read_head_o is combinational from the same-cycle queue outputs and registered state.
- Scoreboard update latency: 1 cycle. An instruction issued at edge N makes its rd busy to the decision made in cycle N+1.
- Writeback latency: a clear taken at edge N makes the register issuable from cycle N+1.
- exe_ready_i low blocks both slots. The queue holds its content, and the state does not change apart from writeback clears and the stall count.
- Reset asserted mid-DRAIN: immediate return to RUN with the scoreboard empty.

## Test plan
- Independent pair: slot0 add x1←x2,x3; slot1 add x4←x5,x6; exe_ready_i=1 → read_head_o=2'b11. Next cycle busy_o[1]=1 and busy_o[4]=1.
- Intra-pair RAW: slot0 x5←…; slot1 reads x5 → read_head_o=2'b01. The next cycle with slot 1 moved to the head and busy[5] set → read_head_o=0 and stall_cnt_o increments. After wb_valid_i[0]=1 with wb_rd_i[0]=5 → issues the following cycle.
- Dual mem: mem_i=2'b11, no register hazards → read_head_o=2'b01. x0 as rd in both slots → no WAW block and busy_o[0] stays 0.
- Serializing: busy[7]=1 and slot0 serial_i=1 → drain_o=1 and read_head_o=0. After writeback clears x7 → read_head_o=2'b01 and drain_o=0 next cycle, even though slot 1 is independent.
- Set-beats-clear and flush: issue x9 while wb_rd_i=9 is valid in the same cycle → busy_o[9]=1. Then flush_i=1 → read_head_o=0, and next cycle busy_o=0 with state RUN.
- Saturation and reset: preload the counter near all-ones and stall → stall_cnt_o holds all-ones. Assert rst_i asynchronously mid-DRAIN → all outputs return to reset values without a clock edge.
